// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2^MUL_STEP shift-add multiply,
// restoring divide, valid/ready on both sides and a kill input for pipeline flushes.
module muldiv_unit #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam int CW       = $clog2(XLEN);
    localparam int MUL_ITER = XLEN / MUL_STEP;
    localparam logic [CW-1:0]   MUL_LAST = CW'(MUL_ITER - 1);
    localparam logic [CW-1:0]   DIV_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_X   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_X    = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

    state_t state_r, state_s;

    logic [2:0]        op_r;
    logic [CW-1:0]     cnt_r;
    logic [2*XLEN-1:0] acc_r, mcand_r;
    logic [XLEN-1:0]   mplier_r;
    logic              bsign_r;
    logic [XLEN-1:0]   rem_r, dvd_r, dvsr_r;
    logic              neg_q_r, neg_r_r, special_r;
    logic [XLEN-1:0]   special_res_r;
    logic              resp_valid_r;
    logic [XLEN-1:0]   resp_data_r;

    logic              accept_s, finish_s;
    logic              a_sgn_s, b_sgn_s, div_sgn_s, a_neg_s, b_neg_s;
    logic [2*XLEN-1:0] a_ext_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s;
    logic              spec_s;
    logic [XLEN-1:0]   spec_res_s;
    logic [2*XLEN-1:0] pp_s, mul_acc_s, mcand_nxt_s, mul_fix_s;
    logic [XLEN-1:0]   mul_res_s;
    logic [XLEN:0]     rem_sh_s, diff_s;
    logic              qbit_s;
    logic [XLEN-1:0]   rem_nxt_s, quo_nxt_s, quo_fix_s, rem_fix_s, div_res_s;

    assign req_ready  = (state_r == ST_IDLE) && reset_n;
    assign busy       = (state_r != ST_IDLE);
    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;

    assign accept_s = req_valid && req_ready && !kill;
    assign finish_s = !kill &&
                      (((state_r == ST_MUL) && (cnt_r == MUL_LAST)) ||
                       ((state_r == ST_DIV) && (special_r || (cnt_r == DIV_LAST))));

    // Operand conditioning at the accepting edge: extension, magnitudes, special cases
    assign a_sgn_s   = (req_op == OP_MULH) || (req_op == OP_MULHSU);
    assign b_sgn_s   = (req_op == OP_MULH);
    assign a_ext_s   = a_sgn_s ? {{XLEN{req_a[XLEN-1]}}, req_a} : {ZERO_X, req_a};
    assign div_sgn_s = !req_op[0];
    assign a_neg_s   = div_sgn_s && req_a[XLEN-1];
    assign b_neg_s   = div_sgn_s && req_b[XLEN-1];
    assign a_mag_s   = a_neg_s ? (ZERO_X - req_a) : req_a;
    assign b_mag_s   = b_neg_s ? (ZERO_X - req_b) : req_b;

    // Divide-by-zero and signed overflow results, resolved without iterating
    always_comb begin
        spec_s     = 1'b0;
        spec_res_s = ZERO_X;
        if (req_b == ZERO_X) begin
            spec_s     = 1'b1;
            spec_res_s = req_op[1] ? req_a : ONES_X;
        end else if (div_sgn_s && (req_a == MIN_X) && (req_b == ONES_X)) begin
            spec_s     = 1'b1;
            spec_res_s = req_op[1] ? ZERO_X : req_a;
        end else begin
            spec_s     = 1'b0;
            spec_res_s = ZERO_X;
        end
    end

    // One multiply iteration: add the partial product of the low multiplier digit
    always_comb begin
        pp_s = {(2*XLEN){1'b0}};
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier_r[i]) begin
                pp_s = pp_s + (mcand_r << i);
            end else begin
                pp_s = pp_s;
            end
        end
    end

    // A signed multiplier's MSB weighs -2^(XLEN-1): subtract a<<XLEN on the last step
    assign mul_acc_s   = acc_r + pp_s;
    assign mcand_nxt_s = mcand_r << MUL_STEP;
    assign mul_fix_s   = bsign_r ? (mul_acc_s - mcand_nxt_s) : mul_acc_s;
    assign mul_res_s   = (op_r == OP_MUL) ? mul_fix_s[XLEN-1:0] : mul_fix_s[2*XLEN-1:XLEN];

    assign rem_sh_s  = {rem_r, dvd_r[XLEN-1]};
    assign diff_s    = rem_sh_s - {1'b0, dvsr_r};
    assign qbit_s    = !diff_s[XLEN];
    assign rem_nxt_s = qbit_s ? diff_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
    assign quo_nxt_s = {dvd_r[XLEN-2:0], qbit_s};
    assign quo_fix_s = neg_q_r ? (ZERO_X - quo_nxt_s) : quo_nxt_s;
    assign rem_fix_s = neg_r_r ? (ZERO_X - rem_nxt_s) : rem_nxt_s;
    assign div_res_s = op_r[1] ? rem_fix_s : quo_fix_s;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state; kill wins over every other transition
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = req_op[2] ? ST_DIV : ST_MUL;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (kill) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == MUL_LAST) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_MUL;
                end
            end
            ST_DIV: begin
                if (kill) begin
                    state_s = ST_IDLE;
                end else if (special_r || (cnt_r == DIV_LAST)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DIV;
                end
            end
            ST_DONE: begin
                if (kill || resp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath: operand latch on accept, iteration updates, registered response
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_r          <= 3'd0;
            cnt_r         <= {CW{1'b0}};
            acc_r         <= {(2*XLEN){1'b0}};
            mcand_r       <= {(2*XLEN){1'b0}};
            mplier_r      <= ZERO_X;
            bsign_r       <= 1'b0;
            rem_r         <= ZERO_X;
            dvd_r         <= ZERO_X;
            dvsr_r        <= ZERO_X;
            neg_q_r       <= 1'b0;
            neg_r_r       <= 1'b0;
            special_r     <= 1'b0;
            special_res_r <= ZERO_X;
            resp_valid_r  <= 1'b0;
            resp_data_r   <= ZERO_X;
        end else begin
            if (accept_s) begin
                op_r          <= req_op;
                cnt_r         <= {CW{1'b0}};
                acc_r         <= {(2*XLEN){1'b0}};
                mcand_r       <= a_ext_s;
                mplier_r      <= req_b;
                bsign_r       <= b_sgn_s && req_b[XLEN-1];
                rem_r         <= ZERO_X;
                dvd_r         <= a_mag_s;
                dvsr_r        <= b_mag_s;
                neg_q_r       <= a_neg_s ^ b_neg_s;
                neg_r_r       <= a_neg_s;
                special_r     <= spec_s;
                special_res_r <= spec_res_s;
            end else if ((state_r == ST_MUL) && !kill) begin
                acc_r    <= mul_acc_s;
                mcand_r  <= mcand_nxt_s;
                mplier_r <= mplier_r >> MUL_STEP;
                cnt_r    <= (cnt_r == MUL_LAST) ? cnt_r : (cnt_r + CNT_ONE);
            end else if ((state_r == ST_DIV) && !kill) begin
                rem_r <= rem_nxt_s;
                dvd_r <= quo_nxt_s;
                cnt_r <= (cnt_r == DIV_LAST) ? cnt_r : (cnt_r + CNT_ONE);
            end else begin
                cnt_r <= cnt_r;
            end

            if (finish_s) begin
                resp_valid_r <= 1'b1;
                if (state_r == ST_MUL) begin
                    resp_data_r <= mul_res_s;
                end else if (special_r) begin
                    resp_data_r <= special_res_r;
                end else begin
                    resp_data_r <= div_res_s;
                end
            end else if ((state_r == ST_DONE) && (kill || resp_ready)) begin
                resp_valid_r <= 1'b0;
            end else begin
                resp_valid_r <= resp_valid_r;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit (XLEN=32, MUL_STEP=2) against an
// arithmetic reference model of the RV32M results and latencies.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_a = 32'd0;
    logic [31:0] req_b = 32'd0;
    logic        kill = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    muldiv_unit #(.XLEN(32), .MUL_STEP(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .kill(kill),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        int              ia, ib;
        logic            ovf;
        logic [31:0]     r;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ia  = a;
        ib  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = 32'd0;
        case (op)
            3'd0: begin p = ua * ub;             r = p[31:0];  end
            3'd1: begin p = sa * sb;             r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub);   r = p[63:32]; end
            3'd3: begin p = ua * ub;             r = p[63:32]; end
            3'd4: r = (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(ia / ib));
            3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(ia % ib));
            default: r = (b == 32'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!op[2]) return 16;
        if (b == 32'd0) return 1;
        if (!op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        return 32;
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 255));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic wait_ready(input string tag);
        int lim = 0;
        while (!req_ready && lim < 100) begin
            @(negedge clk);
            lim++;
        end
        check_eq({tag, "_ready"}, req_ready, 1);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input string tag);
        int          lat;
        logic [31:0] exp, held;
        exp = ref_result(op, a, b);
        wait_ready(tag);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
        check_eq({tag, "_early"}, resp_valid, 0);
        lat = 0;
        while (!resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, lat, ref_latency(op, a, b));
        check_eq({tag, "_data"}, resp_data, exp);
        held = resp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, resp_valid, 1);
            check_eq({tag, "_hold_data"}, resp_data, held);
            check_eq({tag, "_hold_rdy"}, req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_eq({tag, "_drop"}, resp_valid, 0);
        check_eq({tag, "_idle"}, req_ready, 1);
        check_eq({tag, "_keep"}, resp_data, exp);
    endtask

    initial begin
        int seen;
        logic [2:0] rop;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", resp_valid, 0);
        check_eq("rst_data", resp_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_rdy", req_ready, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_rdy", req_ready, 1);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, "mul");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulh");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulh_min");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, "rem");
        run_op(3'd5, 32'd100, 32'd7, 0, "divu");
        run_op(3'd7, 32'd100, 32'd7, 0, "remu");
        run_op(3'd5, 32'd5, 32'd0, 0, "divu_z");
        run_op(3'd6, 32'd5, 32'd0, 0, "rem_z");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
        run_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5, "bp");

        // kill together with a request: dropped, unit stays idle
        req_valid = 1'b1; req_op = 3'd0; req_a = 32'd3; req_b = 32'd3; kill = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; kill = 1'b0;
        check_eq("kill_req_busy", busy, 0);
        check_eq("kill_req_rdy", req_ready, 1);

        // kill in the middle of a divide
        wait_ready("kdiv");
        req_valid = 1'b1; req_op = 3'd4; req_a = 32'd1000; req_b = 32'd3;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check_eq("kill_div_valid", resp_valid, 0);
        check_eq("kill_div_busy", busy, 0);
        check_eq("kill_div_rdy", req_ready, 1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        check_eq("kill_div_silent", seen, 0);
        run_op(3'd0, 32'd12345, 32'd678, 0, "after_kill");

        // reset in the middle of a multiply
        wait_ready("rmul");
        req_valid = 1'b1; req_op = 3'd3; req_a = 32'hDEAD_BEEF; req_b = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("mrst_valid", resp_valid, 0);
        check_eq("mrst_data", resp_data, 0);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_rdy", req_ready, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("mrst_idle", req_ready, 1);

        for (int k = 0; k < 60; k++) begin
            rop = 3'($urandom_range(0, 7));
            run_op(rop, pick_val(), pick_val(), int'($urandom_range(0, 2)), $sformatf("rnd%0d_op%0d", k, rop));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit for the RV32M/RV64M extension. It is the next generation of the execute stage's multiplier path. It handles all eight M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), with a configurable multiplier radix. It uses a valid/ready handshake on both sides so the execute stage can stall on it and the mem stage can back-pressure it. It also has a kill input for pipeline flushes.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64.
MUL_STEP, 2, multiplier bits retired per cycle; legal values 1, 2, 4; must divide XLEN.

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
req_valid  in  1  execute stage presents an operation
req_ready  out  1  unit can accept; high only in IDLE and while reset_n high
req_op  in  3  RISC-V funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
req_a  in  XLEN  rs1 operand (multiplicand/dividend)
req_b  in  XLEN  rs2 operand (multiplier/divisor)
kill  in  1  flush; aborts any in-flight or pending operation
resp_valid  out  1  result available
resp_ready  in  1  consumer (mem stage) takes the result; low means stall
resp_data  out  XLEN  result
busy  out  1  high in MUL, DIV, DONE states

Behaviour:
- States: IDLE, MUL, DIV, DONE.
- Reset:
  - State goes to IDLE; resp_valid 0, resp_data 0, busy 0, iteration counter 0.
  - Reset asserted mid-operation discards the operation with no response.
- Accept:
  - An operation is accepted on the edge where req_valid and req_ready are both high and kill is low.
  - req_a, req_b and req_op are latched at that edge; later changes to them are ignored.
  - kill on the same cycle as req_valid drops the request; state stays IDLE.
- Multiply (ops 0-3):
  - Operands are sign- or zero-extended to 2*XLEN per op: MULH signed x signed; MULHSU signed x unsigned; MULHU and MUL unsigned.
  - MUL's low half is sign-independent.
  - Radix-2^MUL_STEP shift-add over XLEN/MUL_STEP iterations.
  - MUL returns product[XLEN-1:0]; the others return product[2*XLEN-1:XLEN].
- Divide (ops 4-7):
  - Restoring divide on operand magnitudes, 1 quotient bit per cycle, XLEN iterations.
  - Quotient is negated when operand signs differ (signed ops only).
  - Remainder takes the dividend's sign.
- Special cases (resolved in 1 cycle, no iterations):
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return req_a.
  - Signed overflow, a = -2^(XLEN-1) and b = -1: DIV returns req_a; REM returns 0.
- Latency: cycles from the accepting edge to the first cycle with resp_valid high.
  - Multiply: XLEN/MUL_STEP.
  - Divide: XLEN.
  - Special cases: 1.
  - Sign fixup folds into the final iteration edge.
- DONE state:
  - resp_valid is high; resp_data is registered and held stable while resp_ready is low.
  - On the edge where resp_valid and resp_ready are both high, go to IDLE and drop resp_valid.
  - req_ready rises the following cycle; no same-cycle accept.
- kill in MUL/DIV/DONE: go to IDLE on the next edge and drop resp_valid. The aborted result is never presented.
- kill has priority over a simultaneous resp handshake; the consumer treats that result as flushed.
- resp_data keeps its last value after the handshake; only resp_valid qualifies it.
- The iteration counter saturates at its terminal count; it cannot wrap mid-operation.

Test Plan:
- XLEN=32, MUL_STEP=2, MUL a=7, b=0xFFFFFFFD -> resp_data 0xFFFFFFEB; resp_valid high exactly 16 cycles after accept.
- MULH/MULHSU/MULHU with a=b=0xFFFFFFFF -> 0x00000000 / 0xFFFFFFFF / 0xFFFFFFFE; MULH 0x80000000 x 0x80000000 -> 0x40000000.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD with 32-cycle latency; REM on the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with 1-cycle latency; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM on the same operands -> 0.
- Back-pressure: hold resp_ready low 5 cycles in DONE -> resp_valid and resp_data stable, req_ready low; raise resp_ready -> IDLE next cycle, req_ready high.
- Kill at DIV iteration 10 -> resp_valid never asserts, req_ready high next cycle, and the next MUL gives a correct result; reset_n low mid-MUL -> all outputs 0 the next cycle.
